// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor.
//   state_e      : control FSM states (idle / shifting / result held)
//   DefaultWidth : default operand width
package serial_sub_pkg;

    localparam int unsigned DefaultWidth = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtractor.sv
// Combinational one-bit subtractor cell: d = a - b - bin.
// Ports:
//   a, b, bin : minuend bit, subtrahend bit, borrow-in
//   d, bout   : difference bit, borrow-out
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    // Borrow when b exceeds a, or when the bits are equal and a borrow arrives.
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, one bit per clock.
// Computes diff = a - b - bin over WIDTH cycles with a borrow flop between cycles.
// Ports:
//   clk, rst            : clock (rising edge), synchronous active-high reset
//   in_valid / in_ready : operand handshake for a, b, bin
//   out_valid/out_ready : result handshake for diff, bout, zero, ovf
//   diff                : a - b - bin modulo 2^WIDTH
//   bout                : final borrow (unsigned a < b + bin)
//   zero                : diff == 0
//   ovf                 : signed overflow of the subtraction
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero,
    output logic             ovf
);

    localparam int unsigned CntW = $clog2(WIDTH);

    state_e           r_state;
    state_e           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic [CntW-1:0]  r_cnt;
    logic             r_borrow;
    logic             r_sa;
    logic             r_sb;
    logic             r_zero;
    logic             r_ovf;

    logic             w_d;
    logic             w_bout;
    logic             w_last;
    logic [WIDTH-1:0] w_diff_final;

    full_subtractor u_cell (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    assign w_last       = (r_cnt == CntW'(WIDTH - 1));
    // Value diff takes once the final bit shifts in; flags are computed from it
    // in the same cycle so they are stable for the whole DONE state.
    assign w_diff_final = {w_d, r_diff[WIDTH-1:1]};

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (in_valid) w_state_next = StRun;
            StRun:   if (w_last) w_state_next = StDone;
            StDone:  if (out_ready) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_a      <= '0;
            r_b      <= '0;
            r_diff   <= '0;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
            r_sa     <= 1'b0;
            r_sb     <= 1'b0;
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_borrow <= bin;
                        r_cnt    <= '0;
                        r_sa     <= a[WIDTH-1];
                        r_sb     <= b[WIDTH-1];
                    end
                end
                StRun: begin
                    r_a      <= r_a >> 1;
                    r_b      <= r_b >> 1;
                    r_diff   <= w_diff_final;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + CntW'(1);
                    if (w_last) begin
                        r_zero <= (w_diff_final == '0);
                        // w_d is the result sign bit on the final cycle.
                        r_ovf  <= (r_sa != r_sb) && (w_d != r_sa);
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign diff      = r_diff;
    assign bout      = r_borrow;
    assign zero      = r_zero;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         bout;
    logic         zero;
    logic         ovf;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [7:0] a;
        logic [7:0] b;
        logic       bin;
        logic [7:0] diff;
        logic       bout;
        logic       zero;
        logic       ovf;
    } vec_t;

    vec_t vecs [10];

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .bout      (bout),
        .zero      (zero),
        .ovf       (ovf)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [7:0] ta, input logic [7:0] tb, input logic tbin);
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb;
        bin      = tbin;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Counts edges since acceptance until out_valid, bounded.
    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (!out_valid && lat < 50) begin
            tick();
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("in_ready_after_handshake", 32'(in_ready), 32'd1);
        check("out_valid_after_handshake", 32'(out_valid), 32'd0);
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, "_diff"}, 32'(diff), 32'(v.diff));
        check({tag, "_bout"}, 32'(bout), 32'(v.bout));
        check({tag, "_zero"}, 32'(zero), 32'(v.zero));
        check({tag, "_ovf"},  32'(ovf),  32'(v.ovf));
    endtask

    initial begin
        int   lat;
        vec_t bp;
        vec_t post;

        //          a      b      bin   diff   bout  zero  ovf
        vecs[0] = {8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
        vecs[1] = {8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
        vecs[2] = {8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
        vecs[3] = {8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
        vecs[4] = {8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[5] = {8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = {8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0, 1'b0, 1'b0};
        vecs[7] = {8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, 1'b0, 1'b1};
        vecs[8] = {8'h00, 8'h80, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
        vecs[9] = {8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b0, 1'b1};
        bp      = {8'h3C, 8'h11, 1'b0, 8'h2B, 1'b0, 1'b0, 1'b0};
        post    = {8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        bin       = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff",      32'(diff),      32'd0);
        check("rst_bout",      32'(bout),      32'd0);
        check("rst_zero",      32'(zero),      32'd0);
        check("rst_ovf",       32'(ovf),       32'd0);

        for (int i = 0; i < 10; i++) begin
            accept(vecs[i].a, vecs[i].b, vecs[i].bin);
            check($sformatf("v%0d_in_ready_run", i), 32'(in_ready), 32'd0);
            wait_done(0, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(W));
            check_result($sformatf("v%0d", i), vecs[i]);
            handshake();
        end

        // In RUN: a competing in_valid pulse and a stray out_ready must be ignored.
        accept(bp.a, bp.b, bp.bin);
        tick();
        a         = 8'hFF;
        b         = 8'h00;
        bin       = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check("bp_in_ready_run", 32'(in_ready), 32'd0);
        tick();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wait_done(2, lat);
        check("bp_latency", 32'(lat), 32'(W));
        for (int k = 0; k < 5; k++) begin
            check($sformatf("bp_hold%0d_out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_hold%0d_in_ready", k), 32'(in_ready), 32'd0);
            check_result($sformatf("bp_hold%0d", k), bp);
            tick();
        end
        handshake();

        // Reset during the 4th RUN cycle of an op that starts with borrow set.
        accept(8'h00, 8'h01, 1'b1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready",  32'(in_ready),  32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_bout",      32'(bout),      32'd0);
        accept(post.a, post.b, post.bin);
        wait_done(0, lat);
        check("post_latency", 32'(lat), 32'(W));
        check_result("post", post);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
